// File: rtl/grid_pkg.sv
// Shared Tetris grid geometry, line-clear FSM state encoding and the cell address helper.
// Used by the line-clear master, the display scanner and the piece logic.
package grid_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int LW   = 5;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_CHECK     = 3'd2,
    ST_SHIFT_RD  = 3'd3,
    ST_SHIFT_WR  = 3'd4,
    ST_CLEAR_TOP = 3'd5,
    ST_DONE      = 3'd6
  } lc_state_t;

  // Row 0 is the top of the playfield; COLS*ROWS fits in AW bits, so no wrap.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [AW-1:0] r;
    r = AW'(row);
    return r * AW'(COLS) + AW'(col);
  endfunction

endpackage

// File: rtl/grid_row_scan.sv
// Column sequencer and occupancy flag pipeline for scanning one grid row.
// Optional empty-row flag is built only with GRID_LC_EARLY_EXIT_EN.
module grid_row_scan
  import grid_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          scan,
  input  logic [DW-1:0] rdata,
  output logic [CW-1:0] col,
`ifdef GRID_LC_EARLY_EXIT_EN
  output logic          empty,
`endif
  output logic          last,
  output logic          full
);

  logic [CW-1:0] col_r;
  logic          full_r;
`ifdef GRID_LC_EARLY_EXIT_EN
  logic          empty_r;
`endif

  // Read data trails the address by one cycle, so column 0's word is folded in at column 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r  <= {CW{1'b0}};
      full_r <= 1'b1;
`ifdef GRID_LC_EARLY_EXIT_EN
      empty_r <= 1'b1;
`endif
    end else if (restart) begin
      col_r  <= {CW{1'b0}};
      full_r <= 1'b1;
`ifdef GRID_LC_EARLY_EXIT_EN
      empty_r <= 1'b1;
`endif
    end else if (scan) begin
      col_r <= last ? {CW{1'b0}} : col_r + CW'(1);
      if (col_r != {CW{1'b0}}) begin
        full_r <= full_r & (rdata != {DW{1'b0}});
`ifdef GRID_LC_EARLY_EXIT_EN
        empty_r <= empty_r & (rdata == {DW{1'b0}});
`endif
      end
    end
  end

  assign col  = col_r;
  assign last = (col_r == CW'(COLS - 1));
  // Final word of the row is consumed combinationally in the check cycle.
  assign full = full_r & (rdata != {DW{1'b0}});
`ifdef GRID_LC_EARLY_EXIT_EN
  assign empty = empty_r & (rdata == {DW{1'b0}});
`endif

endmodule

// File: rtl/grid_line_clear.sv
// Grid_Mem port-A master: finds full rows bottom-up, shifts the rows above down, clears row 0.
// Optional macro GRID_LC_EARLY_EXIT_EN stops the pass at the first all-empty row.
module grid_line_clear
  import grid_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] lines,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  lc_state_t     state_r, state_s;
  logic [RW-1:0] row_r, row_s;
  logic [RW-1:0] dst_r, dst_s;
  logic [CW-1:0] col_r, col_s;
  logic [LW-1:0] lines_s;
  logic [AW-1:0] addr_s;
  logic          busy_s, done_s, we_s, restart_s;
  logic          scan_en;
  logic [CW-1:0] scan_col;
  logic          scan_last, row_full;
`ifdef GRID_LC_EARLY_EXIT_EN
  logic          row_empty;
`endif

  assign scan_en = (state_r == ST_SCAN);

  grid_row_scan u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .scan    (scan_en),
    .rdata   (mem_rdata),
    .col     (scan_col),
`ifdef GRID_LC_EARLY_EXIT_EN
    .empty   (row_empty),
`endif
    .last    (scan_last),
    .full    (row_full)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    dst_s     = dst_r;
    col_s     = col_r;
    lines_s   = lines;
    busy_s    = busy;
    done_s    = 1'b0;
    addr_s    = mem_addr;
    we_s      = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_SCAN;
          row_s     = RW'(ROWS - 1);
          lines_s   = {LW{1'b0}};
          busy_s    = 1'b1;
          restart_s = 1'b1;
          addr_s    = cell_addr(RW'(ROWS - 1), CW'(0));
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          state_s = ST_CHECK;
        end else begin
          addr_s = cell_addr(row_r, scan_col + CW'(1));
        end
      end
      ST_CHECK: begin
        if (row_full) begin
          lines_s = (&lines) ? lines : lines + LW'(1);
          col_s   = CW'(0);
          if (row_r != RW'(0)) begin
            state_s = ST_SHIFT_RD;
            dst_s   = row_r;
            addr_s  = cell_addr(row_r - RW'(1), CW'(0));
          end else begin
            state_s = ST_CLEAR_TOP;
            we_s    = 1'b1;
            addr_s  = cell_addr(RW'(0), CW'(0));
          end
        end
`ifdef GRID_LC_EARLY_EXIT_EN
        else if (row_empty) begin
          // Gravity: nothing above an empty row can be occupied.
          state_s = ST_DONE;
        end
`endif
        else if (row_r != RW'(0)) begin
          state_s   = ST_SCAN;
          row_s     = row_r - RW'(1);
          restart_s = 1'b1;
          addr_s    = cell_addr(row_r - RW'(1), CW'(0));
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_SHIFT_RD: begin
        state_s = ST_SHIFT_WR;
        we_s    = 1'b1;
        addr_s  = cell_addr(dst_r, col_r);
      end
      ST_SHIFT_WR: begin
        if (col_r == CW'(COLS - 1)) begin
          col_s = CW'(0);
          dst_s = dst_r - RW'(1);
          if (dst_r == RW'(1)) begin
            state_s = ST_CLEAR_TOP;
            we_s    = 1'b1;
            addr_s  = cell_addr(RW'(0), CW'(0));
          end else begin
            state_s = ST_SHIFT_RD;
            addr_s  = cell_addr(dst_r - RW'(2), CW'(0));
          end
        end else begin
          state_s = ST_SHIFT_RD;
          col_s   = col_r + CW'(1);
          addr_s  = cell_addr(dst_r - RW'(1), col_r + CW'(1));
        end
      end
      ST_CLEAR_TOP: begin
        if (col_r == CW'(COLS - 1)) begin
          // Rescan the same row: the row that just moved into it may be full too.
          state_s   = ST_SCAN;
          col_s     = CW'(0);
          restart_s = 1'b1;
          addr_s    = cell_addr(row_r, CW'(0));
        end else begin
          col_s  = col_r + CW'(1);
          we_s   = 1'b1;
          addr_s = cell_addr(RW'(0), col_r + CW'(1));
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      row_r    <= RW'(ROWS - 1);
      dst_r    <= RW'(ROWS - 1);
      col_r    <= CW'(0);
      busy     <= 1'b0;
      done     <= 1'b0;
      lines    <= {LW{1'b0}};
      mem_addr <= {AW{1'b0}};
      mem_we   <= 1'b0;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      dst_r    <= dst_s;
      col_r    <= col_s;
      busy     <= busy_s;
      done     <= done_s;
      lines    <= lines_s;
      mem_addr <= addr_s;
      mem_we   <= we_s;
    end
  end

  // q_a is a RAM output register; forwarding it keeps a row copy at two cycles per cell.
  assign mem_wdata = (state_r == ST_SHIFT_WR) ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_grid_line_clear.sv
// Self-checking bench for grid_line_clear with a behavioural Grid_Mem responder.
// Expectations follow GRID_LC_EARLY_EXIT_EN when it is defined.
module tb_grid_line_clear;
  import grid_pkg::*;

  localparam int NC = COLS * ROWS;
`ifdef GRID_LC_EARLY_EXIT_EN
  localparam int EE = 1;
`else
  localparam int EE = 0;
`endif

  typedef logic [COLS*DW-1:0] prow_t;

  typedef struct {
    string         name;
    logic [19:0]   full_rows;
    int            x_row;
    int            x_col;
    logic [DW-1:0] x_val;
    int            exp_lines;
    int            exp_cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_we;
  logic [LW-1:0] lines;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] img [0:NC-1];
  logic          load_req = 1'b0;
  logic [DW-1:0] q;
  int            done_seen = 0;
  int            write_seen = 0;

  int checks = 0;
  int failures = 0;

  prow_t exp_grid [ROWS];
  int    exp_lines, exp_cyc, exp_wr;

  always #5 clk = ~clk;

  grid_line_clear dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .lines     (lines),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Grid_Mem port A: synchronous read, one-cycle latency; backdoor image load.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NC; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    q <= mem[mem_addr];
    if (done) done_seen <= done_seen + 1;
    if (mem_we) write_seen <= write_seen + 1;
  end
  assign mem_rdata = q;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input prow_t act, input prow_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic prow_t img_row(input int r);
    prow_t v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = img[r*COLS + c];
    return v;
  endfunction

  function automatic prow_t mem_row(input int r);
    prow_t v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = mem[r*COLS + c];
    return v;
  endfunction

  function automatic bit is_full(input prow_t v);
    for (int c = 0; c < COLS; c++) if (v[c*DW +: DW] == '0) return 1'b0;
    return 1'b1;
  endfunction

  // Row-level model: a stack of rows, bottom first; removing a full row drops everything above it by one.
  task automatic model();
    prow_t stk[$];
    prow_t cur;
    int pos;
    stk = {};
    for (int r = ROWS - 1; r >= 0; r--) stk.push_back(img_row(r));
    exp_lines = 0; exp_cyc = 1; exp_wr = 0; pos = ROWS - 1;
    for (int it = 0; it < 4 * ROWS; it++) begin
      cur = stk[ROWS - 1 - pos];
      exp_cyc += COLS + 1;
      if (is_full(cur)) begin
        if (exp_lines < 31) exp_lines++;
        exp_cyc += 2 * COLS * pos + COLS;
        exp_wr  += COLS * pos + COLS;
        stk.delete(ROWS - 1 - pos);
        stk.push_back('0);
      end else if (EE != 0 && cur == '0) begin
        break;
      end else if (pos == 0) begin
        break;
      end else begin
        pos--;
      end
    end
    for (int r = 0; r < ROWS; r++) exp_grid[r] = stk[ROWS - 1 - r];
  endtask

  task automatic load_img();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic img_clear();
    for (int i = 0; i < NC; i++) img[i] = '0;
  endtask

  task automatic img_random();
    int kind;
    img_clear();
    for (int r = 0; r < ROWS; r++) begin
      kind = $urandom_range(0, 3);
      for (int c = 0; c < COLS; c++) begin
        if (kind == 0) img[r*COLS + c] = DW'($urandom_range(1, 255));
        else if (kind == 3) img[r*COLS + c] = '0;
        else img[r*COLS + c] = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(1, 255));
      end
      if (kind == 1 || kind == 2) img[r*COLS + $urandom_range(0, COLS - 1)] = '0;
    end
  endtask

  task automatic run_pass(input string nm, input int tab_lines, input int tab_cyc);
    int cyc, d0, w0;
    bit got;
    model();
    load_img();
    d0 = done_seen; w0 = write_seen;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 4);  // must be ignored while busy
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({nm, ".done_seen"}, int'(got), 1);
    chk({nm, ".cycles"}, cyc, exp_cyc);
    if (tab_cyc >= 0) chk({nm, ".cycles_tab"}, cyc, tab_cyc);
    chk({nm, ".lines"}, int'(lines), exp_lines);
    if (tab_lines >= 0) chk({nm, ".lines_tab"}, int'(lines), tab_lines);
    chk({nm, ".busy_low"}, int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, ".done_pulses"}, done_seen - d0, 1);
    chk({nm, ".writes"}, write_seen - w0, exp_wr);
    chk({nm, ".lines_held"}, int'(lines), exp_lines);
    for (int r = 0; r < ROWS; r++) chk_row($sformatf("%s.row%0d", nm, r), mem_row(r), exp_grid[r]);
  endtask

  initial begin
    vec_t vecs[6];
    int cyc;
    vecs[0] = '{"empty",        20'h00000, -1, 0, 8'd0, 0,  (EE != 0) ? 12   : 221};
    vecs[1] = '{"row19_plus7",  20'h80000, 18, 3, 8'd7, 1,  (EE != 0) ? 424  : 622};
    vecs[2] = '{"rows16_19",    20'hF0000, -1, 0, 8'd0, 4,  (EE != 0) ? 1616 : 1825};
    vecs[3] = '{"row18_hole9",  20'hC0000, 18, 9, 8'd0, 1,  (EE != 0) ? 424  : 622};
    vecs[4] = '{"row0_only",    20'h00001, -1, 0, 8'd0, (EE != 0) ? 0 : 1, (EE != 0) ? 12 : 242};
    vecs[5] = '{"all_full",     20'hFFFFF, -1, 0, 8'd0, 20, (EE != 0) ? 8032 : 8241};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.lines", int'(lines), 0);
    chk("reset.mem_addr", int'(mem_addr), 0);
    chk("reset.mem_we", int'(mem_we), 0);
    chk("reset.mem_wdata", int'(mem_wdata), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      img_clear();
      for (int r = 0; r < ROWS; r++)
        if (vecs[i].full_rows[r]) for (int c = 0; c < COLS; c++) img[r*COLS + c] = 8'd5;
      if (vecs[i].x_row >= 0) img[vecs[i].x_row*COLS + vecs[i].x_col] = vecs[i].x_val;
      run_pass(vecs[i].name, vecs[i].exp_lines, vecs[i].exp_cyc);
    end

    // Asynchronous reset in the middle of a row shift.
    img_clear();
    for (int c = 0; c < COLS; c++) img[(ROWS - 1)*COLS + c] = 8'd5;
    load_img();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!mem_we && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.we_before", int'(mem_we), 1);
    chk("midrst.busy_before", int'(busy), 1);
    #2; rst_n = 1'b0;
    #1;
    chk("midrst.mem_we", int'(mem_we), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    run_pass("after_reset", 1, -1);

    for (int k = 0; k < 6; k++) begin
      img_random();
      run_pass($sformatf("rand%0d", k), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
